// File: rtl/generic_fifo_env_fwft_if.sv
// Bus bundle for the FWFT FIFO envelope: write side, FWFT read side, flush and status.
// Handshake: a write is taken on any edge with wr_op=1, full=0 and clr=0. A pop is taken on
// any edge with rd_op=1, rd_valid=1 and clr=0. rd_data is the oldest word whenever rd_valid=1.
interface generic_fifo_env_fwft_if #(
  parameter int DAT_WIDTH = 32,
  parameter int PTR_WIDTH = 6
);
  logic                 clr;
  logic                 wr_op;
  logic [DAT_WIDTH-1:0] wr_data;
  logic                 full;
  logic                 almost_full;
  logic                 wr_full_err;
  logic                 rd_op;
  logic                 rd_valid;
  logic [DAT_WIDTH-1:0] rd_data;
  logic                 empty;
  logic                 almost_empty;
  logic                 rd_empty_err;
  logic [PTR_WIDTH:0]   entry_used;

  modport master (
    output clr, wr_op, wr_data, rd_op,
    input  full, almost_full, wr_full_err, rd_valid, rd_data,
           empty, almost_empty, rd_empty_err, entry_used
  );

  modport slave (
    input  clr, wr_op, wr_data, rd_op,
    output full, almost_full, wr_full_err, rd_valid, rd_data,
           empty, almost_empty, rd_empty_err, entry_used
  );
endinterface

// File: rtl/generic_fifo_env_fwft.sv
// Single-clock FIFO with first-word-fall-through read side, any depth >= 2,
// programmable almost flags and a synchronous flush. The storage array has a registered read port.
module generic_fifo_env_fwft #(
  parameter int DAT_WIDTH      = 32,
  parameter int NUM_OF_ENTRIES = 64,
  parameter int PTR_WIDTH      = 6,
  parameter int AF_LEVEL       = 60,
  parameter int AE_LEVEL       = 4
) (
  input logic                     clk,
  input logic                     reset_n,
  generic_fifo_env_fwft_if.slave  bus
);

  localparam logic [PTR_WIDTH-1:0] LAST_PTR = PTR_WIDTH'(NUM_OF_ENTRIES - 1);
  localparam logic [PTR_WIDTH:0]   FULL_CNT = (PTR_WIDTH+1)'(NUM_OF_ENTRIES);
  localparam logic [PTR_WIDTH:0]   AF_CNT   = (PTR_WIDTH+1)'(AF_LEVEL);
  localparam logic [PTR_WIDTH:0]   AE_CNT   = (PTR_WIDTH+1)'(AE_LEVEL);

  logic [DAT_WIDTH-1:0] mem [NUM_OF_ENTRIES];

  logic [PTR_WIDTH-1:0] wr_ptr;
  logic [PTR_WIDTH-1:0] rd_ptr;
  logic [PTR_WIDTH:0]   ram_cnt;
  logic                 rd_valid_q;
  logic [DAT_WIDTH-1:0] rd_data_q;
  logic                 wr_full_err_q;
  logic                 rd_empty_err_q;

  logic [PTR_WIDTH:0]   entry_used;
  logic                 full;
  logic                 wr_acc;
  logic                 pop;
  logic                 fetch;

  function automatic logic [PTR_WIDTH-1:0] ptr_next(input logic [PTR_WIDTH-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // entry_used counts the prefetched head word as well as the words still in the array.
  assign entry_used = ram_cnt + {{PTR_WIDTH{1'b0}}, rd_valid_q};
  assign full       = (entry_used == FULL_CNT);

  assign wr_acc = bus.wr_op & ~full & ~bus.clr;
  assign pop    = bus.rd_op & rd_valid_q & ~bus.clr;
  assign fetch  = (ram_cnt != '0) & (~rd_valid_q | pop) & ~bus.clr;

  // fetch needs ram_cnt>0 and a write needs room, so both pointers never address the same slot.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= bus.wr_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ram_cnt        <= '0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      wr_full_err_q  <= 1'b0;
      rd_empty_err_q <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      ram_cnt        <= '0;
      rd_valid_q     <= 1'b0;
      wr_full_err_q  <= 1'b0;
      rd_empty_err_q <= 1'b0;
    end else begin
      wr_full_err_q  <= bus.wr_op & full;
      rd_empty_err_q <= bus.rd_op & ~rd_valid_q;

      if (wr_acc) begin
        wr_ptr <= ptr_next(wr_ptr);
      end

      if (fetch) begin
        rd_data_q  <= mem[rd_ptr];
        rd_ptr     <= ptr_next(rd_ptr);
        rd_valid_q <= 1'b1;
      end else if (pop) begin
        rd_valid_q <= 1'b0;
      end

      case ({wr_acc, fetch})
        2'b10:   ram_cnt <= ram_cnt + 1'b1;
        2'b01:   ram_cnt <= ram_cnt - 1'b1;
        default: ram_cnt <= ram_cnt;
      endcase
    end
  end

  assign bus.full         = full;
  assign bus.almost_full  = (entry_used >= AF_CNT);
  assign bus.empty        = (entry_used == '0);
  assign bus.almost_empty = (entry_used <= AE_CNT);
  assign bus.entry_used   = entry_used;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.rd_data      = rd_data_q;
  assign bus.wr_full_err  = wr_full_err_q;
  assign bus.rd_empty_err = rd_empty_err_q;

endmodule

// File: tb/tb_generic_fifo_env_fwft.sv
// Directed bench for generic_fifo_env_fwft: default 64-deep instance plus a 5-deep instance for wrap.
module tb_generic_fifo_env_fwft;

  logic clk;
  logic reset_n;
  int   n_total;
  int   n_pass;
  int   n_fail;

  generic_fifo_env_fwft_if #(.DAT_WIDTH(32), .PTR_WIDTH(6)) big_if ();
  generic_fifo_env_fwft_if #(.DAT_WIDTH(32), .PTR_WIDTH(3)) small_if ();

  generic_fifo_env_fwft #(
    .DAT_WIDTH(32), .NUM_OF_ENTRIES(64), .PTR_WIDTH(6), .AF_LEVEL(60), .AE_LEVEL(4)
  ) dut_big (
    .clk(clk), .reset_n(reset_n), .bus(big_if)
  );

  generic_fifo_env_fwft #(
    .DAT_WIDTH(32), .NUM_OF_ENTRIES(5), .PTR_WIDTH(3), .AF_LEVEL(4), .AE_LEVEL(1)
  ) dut_small (
    .clk(clk), .reset_n(reset_n), .bus(small_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0; n_pass = 0; n_fail = 0;
    reset_n = 1'b0;
    big_if.clr = 1'b0; big_if.wr_op = 1'b0; big_if.wr_data = '0; big_if.rd_op = 1'b0;
    small_if.clr = 1'b0; small_if.wr_op = 1'b0; small_if.wr_data = '0; small_if.rd_op = 1'b0;

    #22;
    check("rst_empty", big_if.empty, 1);
    check("rst_aempty", big_if.almost_empty, 1);
    check("rst_full", big_if.full, 0);
    check("rst_afull", big_if.almost_full, 0);
    check("rst_rd_valid", big_if.rd_valid, 0);
    check("rst_rd_data", big_if.rd_data, 0);
    check("rst_used", big_if.entry_used, 0);
    check("rst_errs", {big_if.wr_full_err, big_if.rd_empty_err}, 0);
    reset_n = 1'b1;
    tick();

    // Single word latency.
    big_if.wr_op = 1'b1; big_if.wr_data = 32'hA5A5_0001;
    tick();
    big_if.wr_op = 1'b0;
    check("lat_empty_c1", big_if.empty, 0);
    check("lat_valid_c1", big_if.rd_valid, 0);
    tick();
    check("lat_valid_c2", big_if.rd_valid, 1);
    check("lat_data_c2", big_if.rd_data, 32'hA5A5_0001);
    check("lat_used_c2", big_if.entry_used, 1);
    big_if.rd_op = 1'b1;
    tick();
    big_if.rd_op = 1'b0;
    check("lat_pop_valid", big_if.rd_valid, 0);
    check("lat_pop_empty", big_if.empty, 1);

    // Fill to full.
    for (int i = 0; i < 64; i++) begin
      big_if.wr_op = 1'b1; big_if.wr_data = i;
      tick();
      check($sformatf("fill_used_%0d", i), big_if.entry_used, i + 1);
      check($sformatf("fill_afull_%0d", i), big_if.almost_full, (i + 1 >= 60) ? 1 : 0);
    end
    check("fill_full", big_if.full, 1);
    check("fill_err_none", big_if.wr_full_err, 0);
    big_if.wr_data = 32'hDEAD_BEEF;
    tick();
    big_if.wr_op = 1'b0;
    check("ovf_err", big_if.wr_full_err, 1);
    check("ovf_used", big_if.entry_used, 64);
    tick();
    check("ovf_err_pulse", big_if.wr_full_err, 0);

    // Drain in order, one pop per cycle.
    big_if.rd_op = 1'b1;
    for (int i = 0; i < 64; i++) begin
      check($sformatf("drain_valid_%0d", i), big_if.rd_valid, 1);
      check($sformatf("drain_data_%0d", i), big_if.rd_data, i);
      tick();
      check($sformatf("drain_used_%0d", i), big_if.entry_used, 63 - i);
      check($sformatf("drain_aempty_%0d", i), big_if.almost_empty, (63 - i <= 4) ? 1 : 0);
    end
    check("drain_empty", big_if.empty, 1);
    check("drain_valid_end", big_if.rd_valid, 0);
    check("drain_err_none", big_if.rd_empty_err, 0);
    tick();
    big_if.rd_op = 1'b0;
    check("udf_err", big_if.rd_empty_err, 1);
    tick();
    check("udf_err_pulse", big_if.rd_empty_err, 0);

    // Flush with 10 words held, concurrent write and pop ignored.
    for (int i = 0; i < 10; i++) begin
      big_if.wr_op = 1'b1; big_if.wr_data = 100 + i;
      tick();
    end
    big_if.wr_op = 1'b0;
    check("clr_pre_used", big_if.entry_used, 10);
    check("clr_pre_data", big_if.rd_data, 100);
    big_if.clr = 1'b1; big_if.wr_op = 1'b1; big_if.rd_op = 1'b1; big_if.wr_data = 32'h7777;
    tick();
    big_if.clr = 1'b0; big_if.wr_op = 1'b0; big_if.rd_op = 1'b0;
    check("clr_used", big_if.entry_used, 0);
    check("clr_valid", big_if.rd_valid, 0);
    check("clr_empty", big_if.empty, 1);
    check("clr_data_hold", big_if.rd_data, 100);
    check("clr_errs", {big_if.wr_full_err, big_if.rd_empty_err}, 0);
    tick();
    check("clr_errs_after", {big_if.wr_full_err, big_if.rd_empty_err}, 0);
    check("clr_valid_after", big_if.rd_valid, 0);

    // Five-deep instance: stream across pointer wraps.
    for (int i = 0; i < 4; i++) begin
      small_if.wr_op = 1'b1; small_if.wr_data = i;
      tick();
    end
    check("sm_fill_used", small_if.entry_used, 4);
    check("sm_fill_full", small_if.full, 0);
    check("sm_fill_afull", small_if.almost_full, 1);
    small_if.rd_op = 1'b1;
    for (int k = 0; k < 16; k++) begin
      small_if.wr_data = 4 + k;
      check($sformatf("sm_stream_valid_%0d", k), small_if.rd_valid, 1);
      check($sformatf("sm_stream_data_%0d", k), small_if.rd_data, k);
      tick();
      check($sformatf("sm_stream_used_%0d", k), small_if.entry_used, 4);
    end
    small_if.wr_op = 1'b0;
    for (int j = 0; j < 4; j++) begin
      check($sformatf("sm_drain_valid_%0d", j), small_if.rd_valid, 1);
      check($sformatf("sm_drain_data_%0d", j), small_if.rd_data, 16 + j);
      tick();
    end
    small_if.rd_op = 1'b0;
    check("sm_end_empty", small_if.empty, 1);
    check("sm_end_err", small_if.rd_empty_err, 0);

    // Asynchronous reset between edges while data is in flight.
    big_if.wr_op = 1'b1;
    for (int i = 0; i < 3; i++) begin
      big_if.wr_data = 200 + i;
      tick();
    end
    check("ar_pre_used", big_if.entry_used, 3);
    #2;
    reset_n = 1'b0;
    big_if.wr_op = 1'b0;
    #1;
    check("ar_valid", big_if.rd_valid, 0);
    check("ar_data", big_if.rd_data, 0);
    check("ar_used", big_if.entry_used, 0);
    check("ar_empty", big_if.empty, 1);
    check("ar_aempty", big_if.almost_empty, 1);
    check("ar_flags", {big_if.full, big_if.almost_full, big_if.wr_full_err, big_if.rd_empty_err}, 0);
    #10;
    reset_n = 1'b1;
    tick();
    check("ar_post_used", big_if.entry_used, 0);
    big_if.wr_op = 1'b1; big_if.wr_data = 32'h0000_BEEF;
    tick();
    big_if.wr_op = 1'b0;
    check("ar_new_c1_valid", big_if.rd_valid, 0);
    check("ar_new_c1_empty", big_if.empty, 0);
    tick();
    check("ar_new_c2_valid", big_if.rd_valid, 1);
    check("ar_new_c2_data", big_if.rd_data, 32'h0000_BEEF);
    check("ar_new_c2_used", big_if.entry_used, 1);
    big_if.rd_op = 1'b1;
    tick();
    big_if.rd_op = 1'b0;
    check("ar_new_pop_empty", big_if.empty, 1);
    check("ar_new_pop_valid", big_if.rd_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
